// File: rtl/rr_enq_arbiter.sv
// Round-robin arbiter sharing one downstream enq port among NREQ requesters, with bounded bursts.
// Latency: zero cycles; the winner's data and tag pass combinationally to the output port.
// Backpressure: out_enq_rdy=0 blocks every req_enq_rdy; ptr, bcnt and counters hold until a transfer.
//
// Ports:
//   CLK, RST                          clock, synchronous active-high reset
//   req_enq_ena / _v / _rdy           per-requester enq handshake, data packed at [i*DW +: DW]
//   out_enq_ena / _v / _tag           downstream enq request, winner data, winner index
//   out_enq_rdy                       downstream can accept
//   stat_clear / stat_count           counter clear, saturating per-requester transfer counts at [i*CW +: CW]
module rr_enq_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 128,
    parameter int TW    = 2,
    parameter int BURST = 2,
    parameter int CW    = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    req_enq_ena,
    input  logic [NREQ*DW-1:0] req_enq_v,
    output logic [NREQ-1:0]    req_enq_rdy,
    output logic               out_enq_ena,
    output logic [DW-1:0]      out_enq_v,
    output logic [TW-1:0]      out_enq_tag,
    input  logic               out_enq_rdy,
    input  logic               stat_clear,
    output logic [NREQ*CW-1:0] stat_count
);

    logic [TW-1:0] ptr;
    logic [3:0]    bcnt;
    logic [CW-1:0] cnt [NREQ];

    logic [TW-1:0] win;
    logic [TW-1:0] win_nxt;
    logic [TW:0]   sum;
    logic          any;
    logic          xfer;

    assign any  = |req_enq_ena;
    assign xfer = any & out_enq_rdy;

    // Walk the offsets from farthest to nearest so the nearest enabled index
    // (counting upward from ptr with wrap) is the last one written.
    always_comb begin
        win = '0;
        sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (TW+1)'(k);
            if (sum >= (TW+1)'(NREQ)) begin
                sum = sum - (TW+1)'(NREQ);
            end
            if (req_enq_ena[sum[TW-1:0]]) begin
                win = sum[TW-1:0];
            end
        end
    end

    assign win_nxt = (win == TW'(NREQ - 1)) ? '0 : win + TW'(1);

    always_comb begin
        out_enq_ena = any;
        out_enq_v   = '0;
        out_enq_tag = '0;
        req_enq_rdy = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (any && win == TW'(i)) begin
                out_enq_v      = req_enq_v[i*DW +: DW];
                out_enq_tag    = TW'(i);
                req_enq_rdy[i] = out_enq_rdy;
            end
        end
    end

    // Burst bookkeeping: the ptr holder keeps top priority for BURST transfers;
    // a non-holder that wins takes over ptr and starts its own burst.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr  <= '0;
            bcnt <= '0;
        end else if (xfer) begin
            if (win == ptr) begin
                if (({1'b0, bcnt} + 5'd1) < 5'(BURST)) begin
                    bcnt <= bcnt + 4'd1;
                end else begin
                    ptr  <= win_nxt;
                    bcnt <= '0;
                end
            end else if (BURST > 1) begin
                ptr  <= win;
                bcnt <= 4'd1;
            end else begin
                ptr  <= win_nxt;
                bcnt <= '0;
            end
        end
    end

    // Clear beats a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NREQ; i++) begin
            if (RST || stat_clear) begin
                cnt[i] <= '0;
            end else if (xfer && win == TW'(i) && cnt[i] != '1) begin
                cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end

    always_comb begin
        stat_count = '0;
        for (int i = 0; i < NREQ; i++) begin
            stat_count[i*CW +: CW] = cnt[i];
        end
    end

endmodule

// File: tb/tb_rr_enq_arbiter.sv
module tb_rr_enq_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] vbus;

    // Main instance: BURST=2
    logic [3:0]   ena, rdyv;
    logic         oena, ordy, clr;
    logic [127:0] ov;
    logic [1:0]   otag;
    logic [63:0]  cnts;

    // Pure round-robin instance: BURST=1
    logic [3:0]   r_ena, r_rdyv;
    logic         r_oena, r_ordy, r_clr;
    logic [127:0] r_ov;
    logic [1:0]   r_otag;
    logic [63:0]  r_cnts;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_enq_arbiter #(.NREQ(4), .DW(128), .TW(2), .BURST(2), .CW(16)) u_dut (
        .CLK(clk), .RST(rst),
        .req_enq_ena(ena), .req_enq_v(vbus), .req_enq_rdy(rdyv),
        .out_enq_ena(oena), .out_enq_v(ov), .out_enq_tag(otag), .out_enq_rdy(ordy),
        .stat_clear(clr), .stat_count(cnts)
    );

    rr_enq_arbiter #(.NREQ(4), .DW(128), .TW(2), .BURST(1), .CW(16)) u_rr (
        .CLK(clk), .RST(rst),
        .req_enq_ena(r_ena), .req_enq_v(vbus), .req_enq_rdy(r_rdyv),
        .out_enq_ena(r_oena), .out_enq_v(r_ov), .out_enq_tag(r_otag), .out_enq_rdy(r_ordy),
        .stat_clear(r_clr), .stat_count(r_cnts)
    );

    function automatic logic [127:0] dat(int i);
        logic [31:0] w;
        w = 32'hA5A5_0000 + 32'(i);
        return {4{w}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    int tags_b2 [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int tags_b1 [6]  = '{0, 1, 2, 3, 0, 1};
    int tags_bp [8]  = '{1, 1, 1, 2, 2, 2, 2, 3};

    initial begin
        for (int i = 0; i < 4; i++) vbus[i*128 +: 128] = dat(i);
        rst = 1'b1; ena = '0; ordy = 1'b1; clr = 1'b0;
        r_ena = '0; r_ordy = 1'b1; r_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_oena", {127'd0, oena}, 128'd0);
        chk("rst_cnts", {64'd0, cnts}, 128'd0);
        chk("rst_rdy", {124'd0, rdyv}, 128'd0);
        chk("rst_v", ov, 128'd0);

        // Fairness with bursts
        @(negedge clk);
        rst = 1'b0; ena = 4'hF; ordy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("b2_tag%0d", c), {126'd0, otag}, 128'(tags_b2[c]));
            chk($sformatf("b2_v%0d", c), ov, dat(tags_b2[c]));
            chk($sformatf("b2_rdy%0d", c), {124'd0, rdyv}, 128'(4'b1 << tags_b2[c]));
            @(negedge clk);
        end
        ena = '0;
        #1;
        chk("b2_cnt0", {112'd0, cnts[0 +: 16]}, 128'd4);
        chk("b2_cnt1", {112'd0, cnts[16 +: 16]}, 128'd2);
        chk("b2_cnt2", {112'd0, cnts[32 +: 16]}, 128'd2);
        chk("b2_cnt3", {112'd0, cnts[48 +: 16]}, 128'd2);
        chk("idle_oena", {127'd0, oena}, 128'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cnts", {64'd0, cnts}, 128'd0);

        // Pure round robin on the BURST=1 instance
        @(negedge clk);
        r_ena = 4'hF;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("b1_tag%0d", c), {126'd0, r_otag}, 128'(tags_b1[c]));
            chk($sformatf("b1_rdy%0d", c), {124'd0, r_rdyv}, 128'(4'b1 << tags_b1[c]));
            @(negedge clk);
        end
        r_ena = '0;
        #1;
        chk("b1_cnts", {64'd0, r_cnts}, {64'd0, 16'd1, 16'd1, 16'd2, 16'd2});

        // Backpressure: ptr=1, bcnt=0 here; RDY alternates 1,0
        @(negedge clk);
        ena = 4'hF;
        for (int c = 0; c < 8; c++) begin
            ordy = (c % 2 == 0);
            #1;
            chk($sformatf("bp_tag%0d", c), {126'd0, otag}, 128'(tags_bp[c]));
            chk($sformatf("bp_v%0d", c), ov, dat(tags_bp[c]));
            chk($sformatf("bp_rdy%0d", c), {124'd0, rdyv},
                ordy ? 128'(4'b1 << tags_bp[c]) : 128'd0);
            @(negedge clk);
        end
        ena = '0; ordy = 1'b1;
        #1;
        chk("bp_cnts", {64'd0, cnts}, {64'd0, 16'd0, 16'd2, 16'd2, 16'd0});
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Sparse: only req2 (ptr=3 here)
        @(negedge clk);
        ena = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("sp_tag%0d", c), {126'd0, otag}, 128'd2);
            chk($sformatf("sp_rdy%0d", c), {124'd0, rdyv}, 128'(4'b0100));
            @(negedge clk);
        end
        ena = '0;
        #1;
        chk("sp_cnts", {64'd0, cnts}, {64'd0, 16'd0, 16'd6, 16'd0, 16'd0});
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Saturation and clear on req1
        @(negedge clk);
        ena = 4'b0010;
        repeat (65535) @(posedge clk);
        step();
        chk("sat_full", {112'd0, cnts[16 +: 16]}, 128'hFFFF);
        step();
        chk("sat_hold", {112'd0, cnts[16 +: 16]}, 128'hFFFF);
        chk("sat_tag", {126'd0, otag}, 128'd1);
        clr = 1'b1;
        step();
        clr = 1'b0; ena = '0;
        chk("clr_vs_inc", {112'd0, cnts[16 +: 16]}, 128'd0);

        // Reset mid-burst
        @(negedge clk);
        ena = 4'b1000;
        #1;
        chk("mb_tag3", {126'd0, otag}, 128'd3);
        @(negedge clk);
        #1;
        chk("mb_cnt3", {112'd0, cnts[48 +: 16]}, 128'd1);
        ena = 4'hF; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mb_tag0", {126'd0, otag}, 128'd0);
        chk("mb_cnts", {64'd0, cnts}, 128'd0);
        chk("mb_rdy", {124'd0, rdyv}, 128'(4'b0001));
        ena = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
